// File: rtl/std_dffr_pipe.sv
// Purpose : DEPTH-stage valid/ready register pipeline with flush, occupancy count and optional skid entry (macro STD_DFFR_PIPE_SKID_EN).
// Latency : DEPTH cycles from input handshake to out_vld into an empty pipe; one word per cycle sustained.
// Backpressure: bubbles collapse while out_rdy=0; in_rdy drops once all storage is full (registered in_rdy with the skid entry).
module std_dffr_pipe #(
    parameter int                 WIDTH   = 8,
    parameter int                 DEPTH   = 2,
    parameter logic [WIDTH-1:0]   RST_VAL = {WIDTH{1'b0}},
    localparam int                CW      = $clog2(DEPTH + 2)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  flush,
    input  logic                  in_vld,
    output logic                  in_rdy,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  out_vld,
    input  logic                  out_rdy,
    output logic [WIDTH-1:0]      out_data,
    output logic [CW-1:0]         count
);

    // A zero-stage pipe has no output register to drive; refuse to build it.
    generate
        if (DEPTH < 1) begin : g_bad_depth
            $error("std_dffr_pipe: DEPTH must be at least 1");
        end
    endgenerate

    // Per-stage state and the values offered to each stage from upstream.
    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] vld_nxt;
    logic [DEPTH-1:0] ld;
    logic [DEPTH-1:0] we;
    logic [DEPTH-1:0] up_vld;
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] up_dat [DEPTH];
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_nxt;

    // Stage-0 source: either the skid entry (when occupied) or the input port.
    logic             in_hs;
    logic             src0_vld;
    logic [WIDTH-1:0] src0_dat;

    // A stage may load when it is empty or its content moves on this cycle;
    // the chain walks from the output end back to stage 0.
    always_comb begin
        logic chain;
        ld           = '0;
        chain        = ~vld_q[DEPTH-1] | out_rdy;
        ld[DEPTH-1]  = chain;
        for (int k = DEPTH - 2; k >= 0; k--) begin
            chain = ~vld_q[k] | chain;
            ld[k] = chain;
        end
    end

`ifdef STD_DFFR_PIPE_SKID_EN
    logic             skid_vld_q;
    logic             skid_vld_nxt;
    logic             skid_we;
    logic [WIDTH-1:0] skid_dat_q;

    // in_rdy comes straight from the skid flop, so out_rdy never reaches it.
    assign in_rdy   = ~skid_vld_q & ~flush;
    assign in_hs    = in_vld & in_rdy;
    assign src0_vld = skid_vld_q | in_hs;
    assign src0_dat = skid_vld_q ? skid_dat_q : in_data;

    // Park an accepted word when stage 0 cannot take it; release it as soon as stage 0 loads.
    always_comb begin
        skid_we      = in_hs & ~ld[0];
        skid_vld_nxt = skid_vld_q;
        if (flush) begin
            skid_vld_nxt = 1'b0;
        end else if (skid_vld_q && ld[0]) begin
            skid_vld_nxt = 1'b0;
        end else if (skid_we) begin
            skid_vld_nxt = 1'b1;
        end
    end

    // Skid entry storage; data only written when a word actually parks.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            skid_vld_q <= 1'b0;
            skid_dat_q <= RST_VAL;
        end else begin
            skid_vld_q <= skid_vld_nxt;
            if (skid_we && !flush) begin
                skid_dat_q <= in_data;
            end
        end
    end
`else
    // Without a skid entry, in_rdy follows the load chain combinationally.
    assign in_rdy   = ld[0] & ~flush;
    assign in_hs    = in_vld & in_rdy;
    assign src0_vld = in_hs;
    assign src0_dat = in_data;
`endif

    // Build the upstream view of every stage: stage 0 sees the source, stage k sees stage k-1.
    always_comb begin
        up_vld[0] = src0_vld;
        up_dat[0] = src0_dat;
        for (int k = 1; k < DEPTH; k++) begin
            up_vld[k] = vld_q[k-1];
            up_dat[k] = data_q[k-1];
        end
    end

    // Next valid bits and data write enables; flush clears occupancy and freezes data.
    always_comb begin
        vld_nxt = vld_q;
        we      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (ld[k]) begin
                vld_nxt[k] = up_vld[k];
                we[k]      = up_vld[k];
            end
        end
        if (flush) begin
            vld_nxt = '0;
            we      = '0;
        end
    end

    // Occupancy is the population count of the next-state valid bits, so count is a plain flop.
    always_comb begin
        count_nxt = '0;
        for (int k = 0; k < DEPTH; k++) begin
            count_nxt = count_nxt + CW'(vld_nxt[k]);
        end
`ifdef STD_DFFR_PIPE_SKID_EN
        count_nxt = count_nxt + CW'(skid_vld_nxt);
`endif
    end

    // Stage registers: valid bits every cycle, data only when a word is loaded.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_q   <= '0;
            count_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                data_q[k] <= RST_VAL;
            end
        end else begin
            vld_q   <= vld_nxt;
            count_q <= count_nxt;
            for (int k = 0; k < DEPTH; k++) begin
                if (we[k]) begin
                    data_q[k] <= up_dat[k];
                end
            end
        end
    end

    // A flushing cycle must not present a word downstream.
    assign out_vld  = vld_q[DEPTH-1] & ~flush;
    assign out_data = data_q[DEPTH-1];
    assign count    = count_q;

endmodule

// File: tb/tb_std_dffr_pipe.sv
// Directed bench for std_dffr_pipe with WIDTH=8, DEPTH=3, RST_VAL=8'hA5.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_std_dffr_pipe;

    localparam int WIDTH = 8;
    localparam int DEPTH = 3;
    localparam int CW    = $clog2(DEPTH + 2);
`ifdef STD_DFFR_PIPE_SKID_EN
    localparam int CAP   = DEPTH + 1;
`else
    localparam int CAP   = DEPTH;
`endif

    logic             clk;
    logic             rstn;
    logic             flush;
    logic             in_vld;
    logic             in_rdy;
    logic [WIDTH-1:0] in_data;
    logic             out_vld;
    logic             out_rdy;
    logic [WIDTH-1:0] out_data;
    logic [CW-1:0]    count;

    int checks;
    int errors;

    std_dffr_pipe #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .RST_VAL (8'hA5)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .flush    (flush),
        .in_vld   (in_vld),
        .in_rdy   (in_rdy),
        .in_data  (in_data),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .out_data (out_data),
        .count    (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Push one word into an empty pipe with out_rdy=1 and expect it exactly DEPTH cycles later.
    task automatic push_and_watch(input logic [7:0] d, input string tag);
        @(negedge clk);
        in_vld  = 1'b1;
        in_data = d;
        out_rdy = 1'b1;
        #1;
        chk({tag, "_in_rdy"}, 32'(in_rdy), 32'd1);
        chk({tag, "_vld_c0"}, 32'(out_vld), 32'd0);
        for (int c = 1; c <= DEPTH; c++) begin
            @(negedge clk);
            in_vld = 1'b0;
            #1;
            chk({tag, "_vld"}, 32'(out_vld), 32'(c == DEPTH));
            if (c == DEPTH) chk({tag, "_data"}, 32'(out_data), 32'(d));
        end
        @(negedge clk);
        #1;
        chk({tag, "_drained"}, 32'(out_vld), 32'd0);
        chk({tag, "_count0"}, 32'(count), 32'd0);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rstn    = 1'b0;
        flush   = 1'b0;
        in_vld  = 1'b0;
        in_data = '0;
        out_rdy = 1'b0;

        // Reset state
        @(negedge clk);
        #1;
        chk("rst_out_data", 32'(out_data), 32'hA5);
        chk("rst_out_vld",  32'(out_vld),  32'd0);
        chk("rst_count",    32'(count),    32'd0);
        chk("rst_in_rdy",   32'(in_rdy),   32'd1);
        flush = 1'b1;
        #1;
        chk("rst_flush_in_rdy", 32'(in_rdy), 32'd0);
        flush = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // First-word latency
        push_and_watch(8'h11, "lat");

        // Stream 0x00..0x0F back to back
        for (int i = 0; i < 16 + DEPTH; i++) begin
            @(negedge clk);
            in_vld  = (i < 16);
            in_data = 8'(i);
            out_rdy = 1'b1;
            #1;
            if (i < 16) chk("stream_in_rdy", 32'(in_rdy), 32'd1);
            if (i >= DEPTH) begin
                chk("stream_vld",  32'(out_vld),  32'd1);
                chk("stream_data", 32'(out_data), 32'(i - DEPTH));
            end
        end
        @(negedge clk);
        in_vld = 1'b0;
        #1;
        chk("stream_end_vld",   32'(out_vld), 32'd0);
        chk("stream_end_count", 32'(count),   32'd0);

        // Compression under backpressure, then drain in order
        out_rdy = 1'b0;
        for (int i = 0; i <= CAP; i++) begin
            @(negedge clk);
            in_vld  = 1'b1;
            in_data = 8'(i + 1);
            #1;
            chk("fill_in_rdy", 32'(in_rdy), 32'(i < CAP));
            if (i == CAP) chk("fill_count", 32'(count), 32'(CAP));
        end
        for (int j = 0; j <= CAP; j++) begin
            @(negedge clk);
            in_vld  = 1'b0;
            out_rdy = 1'b1;
            #1;
            if (j < CAP) begin
                chk("drain_vld",  32'(out_vld),  32'd1);
                chk("drain_data", 32'(out_data), 32'(j + 1));
            end else begin
                chk("drain_end_vld",   32'(out_vld), 32'd0);
                chk("drain_end_count", 32'(count),   32'd0);
            end
        end

        // Full stages, simultaneous push and pop for 10 cycles
        out_rdy = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            in_vld  = 1'b1;
            in_data = 8'(8'h20 + i);
            #1;
            chk("pre_in_rdy", 32'(in_rdy), 32'd1);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_vld  = 1'b1;
            out_rdy = 1'b1;
            in_data = 8'(8'h30 + i);
            #1;
            chk("full_count",  32'(count),   32'(DEPTH));
            chk("full_in_rdy", 32'(in_rdy),  32'd1);
            chk("full_vld",    32'(out_vld), 32'd1);
            chk("full_data",   32'(out_data),
                (i < DEPTH) ? 32'(8'h20 + i) : 32'(8'h30 + i - DEPTH));
        end

        // Flush on a full pipe overrides in_vld and out_rdy
        @(negedge clk);
        flush   = 1'b1;
        in_vld  = 1'b1;
        in_data = 8'h55;
        out_rdy = 1'b1;
        #1;
        chk("flush_in_rdy",  32'(in_rdy),  32'd0);
        chk("flush_out_vld", 32'(out_vld), 32'd0);
        chk("flush_count",   32'(count),   32'(DEPTH));
        @(negedge clk);
        flush  = 1'b0;
        in_vld = 1'b0;
        #1;
        chk("post_flush_count", 32'(count),    32'd0);
        chk("post_flush_vld",   32'(out_vld),  32'd0);
        chk("post_flush_hold",  32'(out_data), 32'h37);
        push_and_watch(8'h7E, "flush_push");

        // Short reset pulse in the middle of a stream
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_vld  = 1'b1;
            out_rdy = 1'b1;
            in_data = 8'(8'h40 + i);
            #1;
            if (i >= DEPTH) chk("mid_data", 32'(out_data), 32'(8'h40 + i - DEPTH));
        end
        rstn = 1'b0;
        #1;
        chk("arst_vld",    32'(out_vld),  32'd0);
        chk("arst_count",  32'(count),    32'd0);
        chk("arst_data",   32'(out_data), 32'hA5);
        chk("arst_in_rdy", 32'(in_rdy),   32'd1);
        rstn   = 1'b1;
        in_vld = 1'b0;
        for (int c = 0; c < DEPTH + 2; c++) begin
            @(negedge clk);
            #1;
            chk("after_rst_vld",   32'(out_vld), 32'd0);
            chk("after_rst_count", 32'(count),   32'd0);
        end
        push_and_watch(8'h66, "after_rst_push");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
